data_memory_mmio: RTL

Parametrised dual-port data memory with a memory-mapped I/O window, used as the processor's data store in the microarchitecture. Port A serves the CPU load/store path; port B serves a second requester (DMA or display fetch). Both ports see the same address map: RAM words at the bottom, and switches and GPIO registers in an MMIO window. It extends the previous single-write data memory with per-port writes, a collision rule, GPIO direction control, synchronised switch inputs and unmapped-access error flags.

---
 rtl/data_memory_mmio_if.sv | 28 ++
 rtl/data_memory_mmio.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_mmio_if.sv
// Two-port bus bundle for data_memory_mmio: port A is the CPU load/store path,
// port B the second requester (DMA or display fetch).
interface data_memory_mmio_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 19
);
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] qa;
  logic              err_a;

  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic [DATA_W-1:0] qb;
  logic              err_b;

  modport master (
    output we_a, addr_a, wdata_a, we_b, addr_b, wdata_b,
    input  qa, err_a, qb, err_b
  );

  modport slave (
    input  we_a, addr_a, wdata_a, we_b, addr_b, wdata_b,
    output qa, err_a, qb, err_b
  );
endinterface

// File: rtl/data_memory_mmio.sv
// Dual-port data RAM with an MMIO window (switches, GPIO) and unmapped-access flags.
// Define DMEM_SW_DEBOUNCE_EN to add a per-switch debouncer behind the synchroniser.
module data_memory_mmio #(
  parameter int                DATA_W          = 24,
  parameter int                ADDR_W          = 19,
  parameter int                DEPTH           = 1024,
  parameter logic [ADDR_W-1:0] MMIO_BASE       = ADDR_W'('h7FF00),
  parameter int                SW_W            = 4,
  parameter int                GPIO_W          = 24,
  parameter int                DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  data_memory_mmio_if.slave    bus,
  input  logic [SW_W-1:0]      switches,
  input  logic [GPIO_W-1:0]    gpio_in,
  output logic [GPIO_W-1:0]    gpio_out,
  output logic [GPIO_W-1:0]    gpio_oe
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] RAM_TOP = ADDR_W'(DEPTH);

`ifdef DMEM_SW_DEBOUNCE_EN
  localparam bit SW_DEBOUNCE = 1'b1;
`else
  localparam bit SW_DEBOUNCE = 1'b0;
`endif

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_SW,
    RGN_GPIO_OUT,
    RGN_GPIO_DIR,
    RGN_GPIO_IN
  } region_e;

  function automatic region_e decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off    = addr - MMIO_BASE;
    decode = RGN_NONE;
    if (addr < RAM_TOP) begin
      decode = RGN_RAM;
    end else if (addr >= MMIO_BASE) begin
      case (off)
        ADDR_W'(0): decode = RGN_SW;
        ADDR_W'(1): decode = RGN_GPIO_OUT;
        ADDR_W'(2): decode = RGN_GPIO_DIR;
        ADDR_W'(3): decode = RGN_GPIO_IN;
        default:    decode = RGN_NONE;
      endcase
    end
  endfunction

  function automatic logic [DATA_W-1:0] mmio_read(
    input region_e           rgn,
    input logic [SW_W-1:0]   sw,
    input logic [GPIO_W-1:0] gout,
    input logic [GPIO_W-1:0] gdir,
    input logic [GPIO_W-1:0] gin
  );
    case (rgn)
      RGN_SW:       mmio_read = DATA_W'(sw);
      RGN_GPIO_OUT: mmio_read = DATA_W'(gout);
      RGN_GPIO_DIR: mmio_read = DATA_W'(gdir);
      RGN_GPIO_IN:  mmio_read = DATA_W'(gin);
      default:      mmio_read = '0;
    endcase
  endfunction

  region_e          rgn_a, rgn_b;
  logic             wr_clash, wr_b_ok;
  logic [IDX_W-1:0] idx_a, idx_b;

  assign rgn_a    = decode(bus.addr_a);
  assign rgn_b    = decode(bus.addr_b);
  assign idx_a    = bus.addr_a[IDX_W-1:0];
  assign idx_b    = bus.addr_b[IDX_W-1:0];
  // Both ports writing one location: port A wins, port B's write is dropped.
  assign wr_clash = bus.we_a && bus.we_b && (bus.addr_a == bus.addr_b);
  assign wr_b_ok  = bus.we_b && !wr_clash;

  // ---------------------------------------------------------------- inputs
  logic [SW_W-1:0]   sw_s1, sw_s2, sw_reg;
  logic [GPIO_W-1:0] gp_s1, gp_s2, gpio_view;

  // NOTE: non-blocking assignments make each stage take the previous stage's
  // old value, giving a real two-flop chain rather than a single wire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      gp_s1 <= '0;
      gp_s2 <= '0;
    end else begin
      sw_s1 <= switches;
      sw_s2 <= sw_s1;
      gp_s1 <= gpio_in;
      gp_s2 <= gp_s1;
    end
  end

  if (SW_DEBOUNCE && DEBOUNCE_CYCLES > 0) begin : g_debounce
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] db_cnt [SW_W];

    // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sw_reg <= '0;
        for (int i = 0; i < SW_W; i++) db_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < SW_W; i++) begin
          if (sw_s2[i] == sw_reg[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            sw_reg[i] <= sw_s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end else begin : g_no_debounce
    assign sw_reg = sw_s2;
  end

  // Pins configured as outputs read back what we drive, not the pad.
  assign gpio_view = (gp_s2 & ~gpio_oe) | (gpio_out & gpio_oe);

  // ---------------------------------------------------------- GPIO registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
    end else begin
      if (bus.we_a && rgn_a == RGN_GPIO_OUT)      gpio_out <= bus.wdata_a[GPIO_W-1:0];
      else if (wr_b_ok && rgn_b == RGN_GPIO_OUT)  gpio_out <= bus.wdata_b[GPIO_W-1:0];
      if (bus.we_a && rgn_a == RGN_GPIO_DIR)      gpio_oe  <= bus.wdata_a[GPIO_W-1:0];
      else if (wr_b_ok && rgn_b == RGN_GPIO_DIR)  gpio_oe  <= bus.wdata_b[GPIO_W-1:0];
    end
  end

  // -------------------------------------------------------------------- RAM
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q_a, ram_q_b;

  // NOTE: the array and its read registers carry no reset so they map onto
  // block RAM; a write during reset is suppressed by qualifying with rst.
  always_ff @(posedge clk) begin
    if (rst && bus.we_a && rgn_a == RGN_RAM) mem[idx_a] <= bus.wdata_a;
    if (rst && wr_b_ok && rgn_b == RGN_RAM)  mem[idx_b] <= bus.wdata_b;
    ram_q_a <= mem[idx_a];
    ram_q_b <= mem[idx_b];
  end

  // ------------------------------------------------------ read data / errors
  region_e           rgn_q_a, rgn_q_b;
  logic [DATA_W-1:0] mmio_q_a, mmio_q_b;
  logic              err_d_a, err_d_b;

  // NOTE: every always_comb output gets a default first so no path holds a
  // stale value and infers a latch.
  always_comb begin
    err_d_a = 1'b0;
    err_d_b = 1'b0;
    if (rgn_a == RGN_NONE) err_d_a = 1'b1;
    if (bus.we_a && (rgn_a == RGN_SW || rgn_a == RGN_GPIO_IN)) err_d_a = 1'b1;
    if (rgn_b == RGN_NONE) err_d_b = 1'b1;
    if (bus.we_b && (rgn_b == RGN_SW || rgn_b == RGN_GPIO_IN)) err_d_b = 1'b1;
    if (wr_clash) err_d_b = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgn_q_a   <= RGN_NONE;
      rgn_q_b   <= RGN_NONE;
      mmio_q_a  <= '0;
      mmio_q_b  <= '0;
      bus.err_a <= 1'b0;
      bus.err_b <= 1'b0;
    end else begin
      rgn_q_a   <= rgn_a;
      rgn_q_b   <= rgn_b;
      mmio_q_a  <= mmio_read(rgn_a, sw_reg, gpio_out, gpio_oe, gpio_view);
      mmio_q_b  <= mmio_read(rgn_b, sw_reg, gpio_out, gpio_oe, gpio_view);
      bus.err_a <= err_d_a;
      bus.err_b <= err_d_b;
    end
  end

  // Unmapped reads have zero mmio data and a non-RAM region, so they return 0.
  assign bus.qa = (rgn_q_a == RGN_RAM) ? ram_q_a : mmio_q_a;
  assign bus.qb = (rgn_q_b == RGN_RAM) ? ram_q_b : mmio_q_b;

endmodule
